// File: rtl/wakeup_array.sv
// Issue-queue wakeup array: per-entry source readiness tracking with tag broadcast.
// Entries request issue when both sources are ready; a grant frees the entry and broadcasts its dest tag.

module wakeup_entry #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc,
  input  logic             free,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic             disp_src1_rdy,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src2_rdy,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             disp_dst_valid,
  input  logic             bcast_valid,
  input  logic [TAG_W-1:0] bcast_tag,
  input  logic             ext_wake_valid,
  input  logic [TAG_W-1:0] ext_wake_tag,
  output logic             valid,
  output logic             request,
  output logic [TAG_W-1:0] dst_tag,
  output logic             dst_valid
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_rdy;
    logic [TAG_W-1:0] dst_tag;
    logic             dst_valid;
  } entry_t;

  entry_t ent;

  function automatic logic hit(input logic [TAG_W-1:0] t, input logic bv,
                               input logic [TAG_W-1:0] bt, input logic ev,
                               input logic [TAG_W-1:0] et);
    return (bv && bt == t) || (ev && et == t);
  endfunction

  logic wake1, wake2, byp1, byp2;
  assign wake1 = hit(ent.src1_tag, bcast_valid, bcast_tag, ext_wake_valid, ext_wake_tag);
  assign wake2 = hit(ent.src2_tag, bcast_valid, bcast_tag, ext_wake_valid, ext_wake_tag);
  assign byp1  = hit(disp_src1_tag, bcast_valid, bcast_tag, ext_wake_valid, ext_wake_tag);
  assign byp2  = hit(disp_src2_tag, bcast_valid, bcast_tag, ext_wake_valid, ext_wake_tag);

  // alloc only targets invalid entries and free only valid ones, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else if (flush) begin
      ent.valid <= 1'b0;
    end else if (alloc) begin
      ent.valid     <= 1'b1;
      ent.src1_tag  <= disp_src1_tag;
      ent.src1_rdy  <= disp_src1_rdy | byp1;
      ent.src2_tag  <= disp_src2_tag;
      ent.src2_rdy  <= disp_src2_rdy | byp2;
      ent.dst_tag   <= disp_dst_tag;
      ent.dst_valid <= disp_dst_valid;
    end else begin
      if (free) ent.valid <= 1'b0;
      if (ent.valid) begin
        ent.src1_rdy <= ent.src1_rdy | wake1;
        ent.src2_rdy <= ent.src2_rdy | wake2;
      end
    end
  end

  assign valid     = ent.valid;
  assign request   = ent.valid & ent.src1_rdy & ent.src2_rdy;
  assign dst_tag   = ent.dst_tag;
  assign dst_valid = ent.dst_valid;

endmodule

module wakeup_array #(
  parameter int NUM_ENTRIES = 8,
  parameter int TAG_W       = 6,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [TAG_W-1:0]       disp_src1_tag,
  input  logic [TAG_W-1:0]       disp_src2_tag,
  input  logic                   disp_src1_rdy,
  input  logic                   disp_src2_rdy,
  input  logic [TAG_W-1:0]       disp_dst_tag,
  input  logic                   disp_dst_valid,
  output logic [IDX_W-1:0]       disp_index,
  output logic [NUM_ENTRIES-1:0] request_vector,
  input  logic                   grant_valid,
  input  logic [IDX_W-1:0]       grant_index,
  input  logic                   ext_wake_valid,
  input  logic [TAG_W-1:0]       ext_wake_tag,
  output logic                   bcast_valid,
  output logic [TAG_W-1:0]       bcast_tag,
  input  logic                   flush,
  output logic [IDX_W:0]         occupancy,
  output logic                   grant_err
);

  logic [NUM_ENTRIES-1:0]            valid, alloc_vec, free_vec, dst_valid;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0] dst_tag;
  logic                              disp_fire, grant_ok;

  // free list comes from registered valid bits only, so a same-cycle grant cannot be reused
  always_comb begin
    disp_index = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) disp_index = IDX_W'(i);
  end

  assign disp_ready = ~&valid & ~flush;
  assign disp_fire  = disp_valid & disp_ready;
  assign grant_ok   = grant_valid & request_vector[grant_index];

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
    assign alloc_vec[i] = disp_fire && (disp_index == IDX_W'(i));
    assign free_vec[i]  = grant_ok && (grant_index == IDX_W'(i));

    wakeup_entry #(.TAG_W(TAG_W)) u_ent (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .alloc          (alloc_vec[i]),
      .free           (free_vec[i]),
      .disp_src1_tag  (disp_src1_tag),
      .disp_src1_rdy  (disp_src1_rdy),
      .disp_src2_tag  (disp_src2_tag),
      .disp_src2_rdy  (disp_src2_rdy),
      .disp_dst_tag   (disp_dst_tag),
      .disp_dst_valid (disp_dst_valid),
      .bcast_valid    (bcast_valid),
      .bcast_tag      (bcast_tag),
      .ext_wake_valid (ext_wake_valid),
      .ext_wake_tag   (ext_wake_tag),
      .valid          (valid[i]),
      .request        (request_vector[i]),
      .dst_tag        (dst_tag[i]),
      .dst_valid      (dst_valid[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_valid <= 1'b0;
      bcast_tag   <= '0;
      occupancy   <= '0;
      grant_err   <= 1'b0;
    end else begin
      if (grant_valid && !request_vector[grant_index]) grant_err <= 1'b1;
      if (flush) begin
        bcast_valid <= 1'b0;
        occupancy   <= '0;
      end else begin
        bcast_valid <= grant_ok & dst_valid[grant_index];
        if (grant_ok) bcast_tag <= dst_tag[grant_index];
        if (disp_fire && !grant_ok)      occupancy <= occupancy + 1'b1;
        else if (!disp_fire && grant_ok) occupancy <= occupancy - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wakeup_array.sv
// Bench for wakeup_array: directed scenarios then random traffic against an entry-table model.
module tb_wakeup_array;
  localparam int N = 8, TW = 6, IW = 3;

  logic clk = 0, rst = 0;
  logic disp_valid = 0, disp_ready;
  logic [TW-1:0] disp_src1_tag = 0, disp_src2_tag = 0, disp_dst_tag = 0;
  logic disp_src1_rdy = 0, disp_src2_rdy = 0, disp_dst_valid = 0;
  logic [IW-1:0] disp_index;
  logic [N-1:0] request_vector;
  logic grant_valid = 0;
  logic [IW-1:0] grant_index = 0;
  logic ext_wake_valid = 0;
  logic [TW-1:0] ext_wake_tag = 0;
  logic bcast_valid;
  logic [TW-1:0] bcast_tag;
  logic flush = 0;
  logic [IW:0] occupancy;
  logic grant_err;

  int tests = 0, fails = 0;

  wakeup_array #(.NUM_ENTRIES(N), .TAG_W(TW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .disp_dst_valid(disp_dst_valid),
    .disp_index(disp_index), .request_vector(request_vector),
    .grant_valid(grant_valid), .grant_index(grant_index),
    .ext_wake_valid(ext_wake_valid), .ext_wake_tag(ext_wake_tag),
    .bcast_valid(bcast_valid), .bcast_tag(bcast_tag), .flush(flush),
    .occupancy(occupancy), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  // reference: a table of uops, each knowing whether its operands have arrived
  bit m_valid[N], m_s1r[N], m_s2r[N], m_dv[N];
  int m_s1t[N], m_s2t[N], m_dt[N];
  bit m_bv, m_err;
  int m_bt;

  function automatic bit m_ready_src(int i);
    return m_valid[i] && m_s1r[i] && m_s2r[i];
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic bit woken(int t, bit bv, int bt);
    return (bv && bt == t) || (ext_wake_valid && int'(ext_wake_tag) == t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [31:0] rv = 0;
    int ff = m_first_free();
    for (int i = 0; i < N; i++) rv[i] = m_ready_src(i);
    chk("disp_ready", 32'(disp_ready), 32'((ff >= 0) && !flush));
    if (ff >= 0) chk("disp_index", 32'(disp_index), 32'(ff));
    chk("request_vector", 32'(request_vector), rv);
    chk("occupancy", 32'(occupancy), 32'(m_count()));
    chk("bcast_valid", 32'(bcast_valid), 32'(m_bv));
    chk("bcast_tag", 32'(bcast_tag), 32'(m_bt));
    chk("grant_err", 32'(grant_err), 32'(m_err));
  endtask

  task automatic model_edge();
    bit ob = m_bv;
    int obt = m_bt, ff = m_first_free(), gi = int'(grant_index);
    bit gok;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_s1r[i] = 0; m_s2r[i] = 0;
      end
      m_bv = 0; m_bt = 0; m_err = 0;
      return;
    end
    gok = grant_valid && m_ready_src(gi);
    if (grant_valid && !gok) m_err = 1;
    for (int i = 0; i < N; i++) if (m_valid[i]) begin
      if (woken(m_s1t[i], ob, obt)) m_s1r[i] = 1;
      if (woken(m_s2t[i], ob, obt)) m_s2r[i] = 1;
    end
    if (flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_bv = 0;
      return;
    end
    if (gok) begin
      m_valid[gi] = 0; m_bv = m_dv[gi]; m_bt = m_dt[gi];
    end else m_bv = 0;
    if (disp_valid && ff >= 0) begin
      m_valid[ff] = 1;
      m_s1t[ff] = int'(disp_src1_tag); m_s2t[ff] = int'(disp_src2_tag);
      m_s1r[ff] = disp_src1_rdy || woken(int'(disp_src1_tag), ob, obt);
      m_s2r[ff] = disp_src2_rdy || woken(int'(disp_src2_tag), ob, obt);
      m_dt[ff] = int'(disp_dst_tag); m_dv[ff] = disp_dst_valid;
    end
  endtask

  task automatic tick();
    #1;
    if (!rst) model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; grant_valid = 0; ext_wake_valid = 0; flush = 0;
  endtask

  task automatic dispatch(input int s1t, input bit s1r, input int s2t, input bit s2r,
                          input int dt, input bit dv);
    disp_valid = 1;
    disp_src1_tag = TW'(s1t); disp_src1_rdy = s1r;
    disp_src2_tag = TW'(s2t); disp_src2_rdy = s2r;
    disp_dst_tag = TW'(dt); disp_dst_valid = dv;
    tick();
    disp_valid = 0;
  endtask

  task automatic grant(input int gi);
    grant_valid = 1; grant_index = IW'(gi);
    tick();
    grant_valid = 0;
  endtask

  initial begin
    idle();
    rst = 1; tick(); tick(); rst = 0;
    #1;
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_disp_index", 32'(disp_index), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_bcast_valid", 32'(bcast_valid), 0);
    chk("rst_bcast_tag", 32'(bcast_tag), 0);
    chk("rst_grant_err", 32'(grant_err), 0);

    // fill the queue with ready uops
    for (int i = 0; i < N; i++) begin
      #1 chk("fill_index", 32'(disp_index), 32'(i));
      dispatch(40 + i, 1, 50 + i, 1, 16 + i, 1);
    end
    #1;
    chk("full_occupancy", 32'(occupancy), 8);
    chk("full_disp_ready", 32'(disp_ready), 0);
    chk("full_request", 32'(request_vector), 32'hFF);

    // grant while full with a dispatch pending: slot reusable only next cycle
    disp_valid = 1; disp_src1_rdy = 1; disp_src2_rdy = 1;
    grant(4);
    disp_valid = 0;
    #1;
    chk("reuse_disp_ready", 32'(disp_ready), 1);
    chk("reuse_disp_index", 32'(disp_index), 4);
    chk("reuse_occupancy", 32'(occupancy), 7);
    chk("grant_bcast_tag", 32'(bcast_tag), 20);

    // external wakeup of an operand
    flush = 1; tick(); flush = 0;
    dispatch(5, 0, 1, 1, 30, 1);
    #1 chk("ext_before", 32'(request_vector), 0);
    ext_wake_valid = 1; ext_wake_tag = 5; tick(); ext_wake_valid = 0;
    #1 chk("ext_after", 32'(request_vector), 32'h01);

    // back-to-back dependency through the broadcast
    flush = 1; tick(); flush = 0;
    dispatch(1, 1, 1, 1, 20, 1);
    dispatch(1, 1, 1, 1, 21, 1);
    dispatch(1, 1, 1, 1, 9, 1);
    dispatch(9, 0, 1, 1, 22, 1);
    grant(2);
    #1;
    chk("dep_bcast_valid", 32'(bcast_valid), 1);
    chk("dep_bcast_tag", 32'(bcast_tag), 9);
    chk("dep_wait", 32'(request_vector[3]), 0);
    tick();
    #1 chk("dep_wake", 32'(request_vector[3]), 1);

    // dispatch catches a broadcast of its own source tag
    flush = 1; tick(); flush = 0;
    dispatch(1, 1, 1, 1, 7, 1);
    grant(0);
    dispatch(7, 0, 2, 1, 33, 0);
    #1 chk("bypass_request", 32'(request_vector), 32'h01);

    // grant to an empty slot, then flush during live traffic
    grant(5);
    #1;
    chk("err_set", 32'(grant_err), 1);
    chk("err_no_bcast", 32'(bcast_valid), 0);
    chk("err_occupancy", 32'(occupancy), 1);
    dispatch(3, 1, 3, 1, 11, 1);
    dispatch(3, 1, 3, 1, 12, 1);
    flush = 1; disp_valid = 1; grant_valid = 1; grant_index = 0;
    tick();
    idle();
    #1;
    chk("flush_occupancy", 32'(occupancy), 0);
    chk("flush_request", 32'(request_vector), 0);
    chk("flush_err_kept", 32'(grant_err), 1);
    chk("flush_bcast", 32'(bcast_valid), 0);

    // random traffic
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 500; c++) begin
      int pick = -1;
      disp_valid = ($urandom_range(0, 3) != 0);
      disp_src1_tag = TW'($urandom_range(0, 7)); disp_src1_rdy = ($urandom_range(0, 2) == 0);
      disp_src2_tag = TW'($urandom_range(0, 7)); disp_src2_rdy = ($urandom_range(0, 2) == 0);
      disp_dst_tag = TW'($urandom_range(0, 7)); disp_dst_valid = ($urandom_range(0, 3) != 0);
      ext_wake_valid = ($urandom_range(0, 3) == 0);
      ext_wake_tag = TW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 49) == 0);
      grant_valid = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) if (m_ready_src(i) && $urandom_range(0, 1) == 1) pick = i;
      grant_index = (pick >= 0 && $urandom_range(0, 7) != 0) ? IW'(pick) : IW'($urandom_range(0, N - 1));
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
